// File: rtl/display_pkg.sv
// display_pkg: shared widths and "all dark" constants for the display scanner
package display_pkg;
  localparam int ENCODING_WIDTH = 7;
  localparam int SEGMENT_WIDTH = 8;
  localparam int BRIGHT_W = 3;
  localparam logic [31:0] ANODE_OFF = '1;
  localparam logic [31:0] SEG_OFF = '1;
endpackage

// File: rtl/display_scanner_scan_timer.sv
// scan_timer: slot counter cnt (0..PRESCALE-1) and digit index idx with slot/frame strobes
// ports: clk, rst (active-low sync); cnt_o, idx_o; slot_start_o (cnt==0),
// frame_start_o (cnt==0 && idx==0), frame_end_o (last cycle of the frame)
module scan_timer #(
  parameter int PRESCALE = 50000,
  parameter int DISPLAY_NUM = 4,
  parameter int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
  parameter int IW = (DISPLAY_NUM > 1) ? $clog2(DISPLAY_NUM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt_o,
  output logic [IW-1:0] idx_o,
  output logic          slot_start_o,
  output logic          frame_start_o,
  output logic          frame_end_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic wrap, last_idx;
  always_comb begin
    wrap = cnt_q == CW'(PRESCALE - 1);
    last_idx = idx_q == IW'(DISPLAY_NUM - 1);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    idx_d = !wrap ? idx_q : last_idx ? '0 : idx_q + IW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
  assign cnt_o = cnt_q;
  assign idx_o = idx_q;
  assign slot_start_o = cnt_q == '0;
  assign frame_start_o = slot_start_o && idx_q == '0;
  assign frame_end_o = wrap && last_idx;
endmodule

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexes digit groups onto a shared 7-seg display with blanking and PWM
// ports: clk, rst (active-low sync); displays_flattened (active-low groups), enable, brightness;
// segments (active-low, registered), anodes (active-low, registered), frame_tick (frame-start pulse)
module display_scanner
  import display_pkg::*;
#(
  parameter int DISPLAY_NUM = 4,
  parameter int SEGMENT_WIDTH = display_pkg::SEGMENT_WIDTH,
  parameter int PRESCALE = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DISPLAY_NUM*SEGMENT_WIDTH-1:0] displays_flattened,
  input  logic                                 enable,
  input  logic [BRIGHT_W-1:0]                  brightness,
  output logic [SEGMENT_WIDTH-1:0]             segments,
  output logic [DISPLAY_NUM-1:0]               anodes,
  output logic                                 frame_tick
);
  localparam int STEP = (PRESCALE - BLANK_CYCLES) / 8;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DISPLAY_NUM > 1) ? $clog2(DISPLAY_NUM) : 1;
  localparam int FW = DISPLAY_NUM * SEGMENT_WIDTH;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic slot_start, frame_start, frame_end, on;
  logic [31:0] win_end;
  logic [FW-1:0] snap_q, snap_d;
  logic [BRIGHT_W-1:0] bri_q, bri_d;
  logic [SEGMENT_WIDTH-1:0] segments_q, segments_d;
  logic [DISPLAY_NUM-1:0] anodes_q, anodes_d;
  logic frame_tick_q, frame_tick_d;
  scan_timer #(
    .PRESCALE(PRESCALE),
    .DISPLAY_NUM(DISPLAY_NUM),
    .CW(CW),
    .IW(IW)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .cnt_o(cnt),
    .idx_o(idx),
    .slot_start_o(slot_start),
    .frame_start_o(frame_start),
    .frame_end_o(frame_end)
  );
  // Brightness only changes at cnt==0, so the window below is fixed for a whole slot.
  always_comb begin
    win_end = 32'(BLANK_CYCLES) + (32'(bri_q) + 32'd1) * 32'(STEP);
    on = enable && 32'(cnt) >= 32'(BLANK_CYCLES) && 32'(cnt) < win_end;
    snap_d = frame_start ? displays_flattened : snap_q;
    bri_d = slot_start ? brightness : bri_q;
    anodes_d = ANODE_OFF[DISPLAY_NUM-1:0] & ~(DISPLAY_NUM'(on) << idx);
    segments_d = snap_q[32'(idx) * SEGMENT_WIDTH +: SEGMENT_WIDTH];
    frame_tick_d = frame_end;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_q <= '1;
      bri_q <= '0;
      segments_q <= SEG_OFF[SEGMENT_WIDTH-1:0];
      anodes_q <= ANODE_OFF[DISPLAY_NUM-1:0];
      frame_tick_q <= 1'b0;
    end else begin
      snap_q <= snap_d;
      bri_q <= bri_d;
      segments_q <= segments_d;
      anodes_q <= anodes_d;
      frame_tick_q <= frame_tick_d;
    end
  end
  assign segments = segments_q;
  assign anodes = anodes_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: randomized and directed checks of display_scanner against a time-based reference model
module tb_display_scanner;
  localparam int P = 24, B = 8, N = 4, W = 8, STEP = 2, FRAME = 96;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic [31:0] flat = '0;
  logic [2:0] brightness = '0;
  logic [7:0] segments;
  logic [3:0] anodes;
  logic frame_tick;
  int errors = 0, checks = 0;
  int t = 0, bri = 0;
  logic [31:0] snap = '1;
  logic [3:0] exp_an = 4'hF;
  logic [7:0] exp_seg = 8'hFF;
  logic exp_ft = 1'b0;

  display_scanner #(.DISPLAY_NUM(N), .SEGMENT_WIDTH(W), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .displays_flattened(flat), .enable(enable),
    .brightness(brightness), .segments(segments), .anodes(anodes), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // t = clock edges since reset release; slot position and digit follow from plain division.
  always @(posedge clk) begin : model
    int c, d;
    bit lit;
    if (!rst) begin
      t = 0; bri = 0; snap = '1;
      exp_an = 4'hF; exp_seg = 8'hFF; exp_ft = 1'b0;
    end else begin
      c = t % P;
      d = (t / P) % N;
      lit = enable && c >= B && c < B + (bri + 1) * STEP;
      exp_an = lit ? ~(4'b0001 << d) : 4'hF;
      exp_seg = snap[d*W +: W];
      exp_ft = (c == P - 1) && (d == N - 1);
      if (c == 0) bri = int'(brightness);
      if (c == 0 && d == 0) snap = flat;
      t++;
    end
  end

  task automatic align(input int m);
    int n;
    n = (m - t % m) % m;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    int first;
    logic [7:0] fseg;
    logic [3:0] fan;
    rst = 1'b0; flat = 32'h12345678; brightness = 3'd7; enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, frame_tick} !== 13'h1FFE) begin
        errors++;
        $display("FAIL reset_hold: an=%h seg=%h ft=%b, want an=f seg=ff ft=0", anodes, segments, frame_tick);
      end
    end
    rst = 1'b1; first = 0; fseg = '0; fan = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        errors++;
        $display("FAIL reset_model t=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b", t, anodes, segments, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (first == 0 && anodes !== 4'hF) begin first = k; fseg = segments; fan = anodes; end
    end
    checks++;
    if (first != 9) begin errors++; $display("FAIL first_lit_latency: got %0d cycles, want 9", first); end
    checks++;
    if (fan !== 4'hE || fseg !== 8'h78) begin
      errors++; $display("FAIL first_lit_value: an=%h seg=%h, want an=e seg=78", fan, fseg);
    end
  endtask

  task automatic test_full_scan;
    int lit_cnt[N];
    int first_lit[N];
    int ticks[$];
    for (int d = 0; d < N; d++) begin lit_cnt[d] = 0; first_lit[d] = -1; end
    align(FRAME);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        errors++;
        $display("FAIL scan_model t=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b", t, anodes, segments, frame_tick, exp_an, exp_seg, exp_ft);
      end
      checks++;
      if ($countones(~anodes) > 1) begin errors++; $display("FAIL one_anode: an=%h, want at most one low", anodes); end
      for (int d = 0; d < N; d++)
        if (anodes === ~(4'b0001 << d)) begin
          lit_cnt[d]++;
          if (first_lit[d] < 0) first_lit[d] = i;
        end
      if (frame_tick === 1'b1) ticks.push_back(i);
    end
    for (int d = 0; d < N; d++) begin
      checks++;
      if (lit_cnt[d] != 32) begin errors++; $display("FAIL lit_cycles digit %0d: got %0d, want 32", d, lit_cnt[d]); end
      checks++;
      if (first_lit[d] != d * P + B) begin
        errors++; $display("FAIL scan_order digit %0d: first lit at %0d, want %0d", d, first_lit[d], d * P + B);
      end
    end
    checks++;
    if (ticks.size() != 2 || ticks[0] != FRAME - 1 || ticks[1] != 2 * FRAME - 1) begin
      errors++; $display("FAIL frame_tick_period: got %0d ticks, want 2 at 95 and 191", ticks.size());
    end
  endtask

  task automatic test_brightness;
    int lit[3];
    int want[3];
    want[0] = 2; want[1] = 2; want[2] = 8;
    for (int s = 0; s < 3; s++) lit[s] = 0;
    brightness = 3'd0;
    align(P);
    for (int i = 0; i < 3 * P; i++) begin
      if (i == P + 12) brightness = 3'd3;
      @(negedge clk);
      checks++;
      if ({anodes, segments, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        errors++;
        $display("FAIL bright_model t=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b", t, anodes, segments, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (anodes !== 4'hF) lit[i / P]++;
    end
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (lit[s] != want[s]) begin errors++; $display("FAIL bright_slot %0d: lit %0d cycles, want %0d", s, lit[s], want[s]); end
    end
  endtask

  task automatic test_snapshot;
    logic [7:0] want_seg[8];
    want_seg = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    brightness = 3'd7;
    align(FRAME);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == P + 6) flat = 32'hAABBCCDD;
      @(negedge clk);
      checks++;
      if ({anodes, segments, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        errors++;
        $display("FAIL snap_model t=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b", t, anodes, segments, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (i % P == B) begin
        checks++;
        if (anodes !== ~(4'b0001 << ((i / P) % N)) || segments !== want_seg[i / P]) begin
          errors++;
          $display("FAIL snapshot slot %0d: an=%h seg=%h, want seg=%h", i / P, anodes, segments, want_seg[i / P]);
        end
      end
    end
  endtask

  task automatic test_enable;
    int ticks[$];
    brightness = 3'd7;
    align(FRAME);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == P + 10) enable = 1'b0;
      if (i == P + 14) enable = 1'b1;
      @(negedge clk);
      checks++;
      if ({anodes, segments, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        errors++;
        $display("FAIL enable_model t=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b", t, anodes, segments, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (i >= P + 10 && i <= P + 13) begin
        checks++;
        if (anodes !== 4'hF) begin errors++; $display("FAIL enable_off i=%0d: an=%h, want f", i, anodes); end
      end
      if (i == P + 14 || i == P + 23 || i == P + 24) begin
        checks++;
        if (anodes !== ((i == P + 24) ? 4'hF : 4'hD)) begin
          errors++; $display("FAIL enable_resume i=%0d: an=%h, want %h", i, anodes, (i == P + 24) ? 4'hF : 4'hD);
        end
      end
      if (frame_tick === 1'b1) ticks.push_back(i);
    end
    checks++;
    if (ticks.size() != 2 || ticks[0] != FRAME - 1 || ticks[1] != 2 * FRAME - 1) begin
      errors++; $display("FAIL enable_tick_period: got %0d ticks, want 2 at 95 and 191", ticks.size());
    end
  endtask

  task automatic test_reset_mid;
    int first;
    logic [7:0] fseg;
    logic [3:0] fan;
    flat = 32'h12345678; brightness = 3'd7;
    align(FRAME);
    for (int i = 0; i < 2 * P + 13; i++) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, frame_tick} !== 13'h1FFE) begin
        errors++;
        $display("FAIL midreset_hold: an=%h seg=%h ft=%b, want an=f seg=ff ft=0", anodes, segments, frame_tick);
      end
    end
    rst = 1'b1; first = 0; fseg = '0; fan = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        errors++;
        $display("FAIL midreset_model t=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b", t, anodes, segments, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (first == 0 && anodes !== 4'hF) begin first = k; fseg = segments; fan = anodes; end
    end
    checks++;
    if (first != 9 || fan !== 4'hE || fseg !== 8'h78) begin
      errors++; $display("FAIL midreset_restart: lit after %0d an=%h seg=%h, want 9 e 78", first, fan, fseg);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0) flat = $urandom;
      if ($urandom_range(0, 19) == 0) brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if ({anodes, segments, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        errors++;
        $display("FAIL random_model t=%0d: an=%h seg=%h ft=%b, want an=%h seg=%h ft=%b", t, anodes, segments, frame_tick, exp_an, exp_seg, exp_ft);
      end
      checks++;
      if ($countones(~anodes) > 1) begin errors++; $display("FAIL random_one_anode: an=%h, want at most one low", anodes); end
    end
  endtask

  initial begin
    test_reset;
    test_full_scan;
    test_brightness;
    test_snapshot;
    test_enable;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Downstream of the multi-device top, which produces displays_flattened: four 8-bit groups, each {dot, 7 segment bits}.
- Time-multiplexes those four groups onto one physical 4-digit seven-segment display with shared segment lines and per-digit anode enables.
- Provides tear-free frame snapshots, anti-ghosting blanking between digits, and 8-level brightness control by pulse-width modulation (PWM).

Parameters:
DISPLAY_NUM, 4, number of digits scanned (ports size with it)
SEGMENT_WIDTH, 8, bits per digit group (7 segments + dot)
PRESCALE, 50000, clock cycles per digit slot
BLANK_CYCLES, 16, cycles at slot start with all anodes off; (PRESCALE - BLANK_CYCLES) must be a positive multiple of 8

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, active-low, synchronous
displays_flattened  input  DISPLAY_NUM*SEGMENT_WIDTH  digit j at bits [j*SEGMENT_WIDTH +: SEGMENT_WIDTH]; active-low segment/dot bits
enable  input  1  0 = display dark, scanning continues
brightness  input  3  on-window = (brightness+1)/8 of the post-blank slot time
segments  output  SEGMENT_WIDTH  active-low segment+dot drive, registered
anodes  output  DISPLAY_NUM  active-low digit enables, one-hot-low or all-high, registered
frame_tick  output  1  one-cycle pulse at each frame start

Behaviour:
- Reset: rst sampled low at a clk edge gives the following next-state values. Any operation in progress is abandoned; there is no partial-slot carry-over.
  - slot counter cnt = 0, digit index idx = 0
  - snapshot = all ones (all segments dark)
  - segments = all ones, anodes = all ones, frame_tick = 0, latched brightness = 0
- Slot counter:
  - cnt counts 0..PRESCALE-1 and wraps to 0.
  - On wrap, idx increments modulo DISPLAY_NUM (DISPLAY_NUM-1 -> 0).
- Snapshot:
  - While cnt==0 and idx==0, the full displays_flattened vector is captured into snapshot at that edge.
  - Input changes mid-frame are invisible until the next frame.
  - The first frame after reset captures on the first cycle after rst is released.
- Brightness latch: brightness is latched at every cnt==0. Changes take effect at the next slot boundary, never mid-slot.
- STEP = (PRESCALE - BLANK_CYCLES)/8 (localparam).
- on = enable && cnt >= BLANK_CYCLES && cnt < BLANK_CYCLES + (brightness_latched+1)*STEP.
- Output registers, one cycle latency from cnt/idx/enable:
  - anodes_next: bit idx = ~on, all other bits = 1.
  - segments_next = snapshot group idx, passed through unchanged (no polarity inversion).
  - frame_tick_next = (cnt==PRESCALE-1 && idx==DISPLAY_NUM-1).
  - frame_tick is therefore high in the same cycle cnt==0, idx==0 is visible.
- At most one anode is low in any cycle. Anodes are all high for ≥ BLANK_CYCLES cycles across every digit change.
- brightness 7 gives full window: on from cnt=BLANK_CYCLES to PRESCALE-1 inclusive. brightness 0 gives STEP cycles.
- enable falling mid-slot: anodes all high from the next cycle. enable rising mid-slot: anode resumes only if still inside the on-window. Counters are never stalled.
- No handshake. Inputs are level, synchronous to clk; displays_flattened comes straight from top's registers and combinational logic.

Decomposition:
- Shared package display_pkg:
  - ENCODING_WIDTH = 7, SEGMENT_WIDTH = 8
  - ANODE_OFF / SEG_OFF all-ones constants
  - brightness width (3)
- One sub-module scan_timer owns cnt, idx and the frame-start/slot-wrap strobes; parameters PRESCALE, DISPLAY_NUM.
- Snapshot, PWM compare and output registers stay in display_scanner.

Test Plan (PRESCALE=24, BLANK_CYCLES=8, STEP=2, DISPLAY_NUM=4):
1. Reset and release:
   - Hold rst=0 for 3 cycles with displays_flattened=32'h12345678 -> anodes=4'hF, segments=8'hFF, frame_tick=0 throughout.
   - After release, snapshot = 32'h12345678.
   - First anode low is anodes=4'hE, 9 cycles after release (BLANK 8 + 1 register), segments=8'h78.
2. Full scan, brightness=7, enable=1:
   - Each digit lit 16 cycles, then 8 dark.
   - anodes sequence E,D,B,7 with segments 78,56,34,12.
   - frame_tick pulses once every 96 cycles.
   - Never two anodes low.
3. Brightness 0 then 3:
   - brightness=0 -> each anode low exactly 2 cycles per slot.
   - Change to 3 at cnt=12 -> current slot unchanged; next slot anode low exactly 8 cycles.
4. Tear-free snapshot: change displays_flattened to 32'hAABBCCDD while idx=1 -> digits 1..3 still show 56,34,12; next frame shows DD,CC,BB,AA.
5. Enable toggle: drop enable at cnt=10 of a lit slot -> anodes=4'hF next cycle; frame_tick period stays 96 cycles; re-raise at cnt=14 -> anode low again from cnt=15 until the window ends.
6. Reset mid-slot: assert rst at idx=2, cnt=13 -> next edge anodes=4'hF, segments=8'hFF, and the restart sequence matches scenario 1.
